// File: rtl/number_entry_pkg.sv
// number_entry_pkg: shared helpers for the number-entry block.
// Holds the single-digit step rule (wrap at a configurable maximum) and the
// width helper used to size each debounce counter.
package number_entry_pkg;

    typedef struct packed {
        logic [31:0] val;
        logic        wrap;
    } step_t;

    // One digit step. Values above dmax (possible after a raw load) wrap to 0
    // on increment, just like dmax itself.
    function automatic step_t digit_step(input logic [31:0] d,
                                         input logic [31:0] dmax,
                                         input logic        up);
        step_t r;
        if (up) begin
            r.wrap = (d >= dmax);
            r.val  = r.wrap ? 32'd0 : d + 32'd1;
        end else begin
            r.wrap = (d == 32'd0);
            r.val  = r.wrap ? dmax : d - 32'd1;
        end
        return r;
    endfunction

    // Counter must be able to hold the value DEB_TICKS.
    function automatic int deb_cnt_w(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/number_entry_btn_debounce.sv
// btn_debounce: one raw push-button channel.
// 2-flop synchroniser, tick-gated stability counter, accepted level register
// and a registered one-clk pulse on each accepted press (rising edge only).
module btn_debounce
    import number_entry_pkg::*;
#(
    parameter int DEB_TICKS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int             CW       = deb_cnt_w(DEB_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // accept a new level once it has differed from stable for DEB_TICKS ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // registered rising-edge detect of the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/number_entry.sv
// number_entry: debounced front-panel multi-digit number entry.
// Each digit has an increment button (and a decrement button when the
// NUMBER_ENTRY_DEC_EN macro is defined). Presses latch sticky pending flags;
// one pending digit is serviced per cycle, lowest index first. With CARRY=1
// a digit wrap ripples into higher digits and a top-digit wrap pulses ovf.
module number_entry
    import number_entry_pkg::*;
#(
    parameter int                        DIGITS    = 2,
    parameter int                        DIG_W     = 4,
    parameter int                        DIG_MAX   = 15,
    parameter logic [DIGITS*DIG_W-1:0]   INIT      = 'h12,
    parameter int                        DEB_TICKS = 16,
    parameter int                        CARRY     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic [DIGITS-1:0]         btn_inc,
`ifdef NUMBER_ENTRY_DEC_EN
    input  logic [DIGITS-1:0]         btn_dec,
`endif
    input  logic                      load,
    input  logic [DIGITS*DIG_W-1:0]   load_val,
    output logic [DIGITS*DIG_W-1:0]   num,
    output logic                      changed,
    output logic                      ovf
);

    localparam int NW = DIGITS * DIG_W;

    logic [DIGITS-1:0] inc_press;
    logic [DIGITS-1:0] pend_inc;
    logic [DIGITS-1:0] pend_dec;
    logic [DIGITS-1:0] clr;
    logic [NW-1:0]     num_q;
    logic [NW-1:0]     num_nxt;
    logic              chg_nxt;
    logic              ovf_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_inc
        btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (btn_inc[g]),
            .press (inc_press[g])
        );
    end

`ifdef NUMBER_ENTRY_DEC_EN
    logic [DIGITS-1:0] dec_press;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (btn_dec[g]),
            .press (dec_press[g])
        );
    end

    // sticky decrement requests; load wipes them
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            pend_dec <= '0;
        end else begin
            pend_dec <= (pend_dec & ~clr) | dec_press;
        end
    end
`else
    assign pend_dec = '0;
`endif

    // pick the lowest pending digit, step it and ripple any carry/borrow
    always_comb begin
        logic  found;
        logic  go;
        logic  up;
        step_t st;
        num_nxt = num_q;
        clr     = '0;
        chg_nxt = 1'b0;
        ovf_nxt = 1'b0;
        found   = 1'b0;
        go      = 1'b0;
        up      = 1'b0;
        st      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!found && (pend_inc[i] || pend_dec[i])) begin
                found   = 1'b1;
                clr[i]  = 1'b1;
                up      = pend_inc[i];
                // inc and dec on the same digit cancel each other
                go      = !(pend_inc[i] && pend_dec[i]);
                chg_nxt = go;
            end
            if (go) begin
                st = digit_step(32'(num_q[i*DIG_W +: DIG_W]), 32'(DIG_MAX), up);
                num_nxt[i*DIG_W +: DIG_W] = DIG_W'(st.val);
                go = (CARRY != 0) && st.wrap;
                if (i == DIGITS - 1) begin
                    ovf_nxt = go;
                end
            end
        end
    end

    // value register, status pulses and sticky increment requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q    <= INIT;
            changed  <= 1'b0;
            ovf      <= 1'b0;
            pend_inc <= '0;
        end else if (load) begin
            num_q    <= load_val;
            changed  <= 1'b1;
            ovf      <= 1'b0;
            pend_inc <= '0;
        end else begin
            num_q    <= num_nxt;
            changed  <= chg_nxt;
            ovf      <= ovf_nxt;
            pend_inc <= (pend_inc & ~clr) | inc_press;
        end
    end

    assign num = num_q;

endmodule

// File: tb/tb_number_entry.sv
// tb_number_entry: drives a CARRY=0 and a CARRY=1 instance with identical
// stimulus and checks both against a behavioural model every cycle.
// Build with NUMBER_ENTRY_DEC_EN defined to exercise the decrement path.
module tb_number_entry;

    localparam int DIGITS  = 2;
    localparam int DIG_W   = 4;
    localparam int DIG_MAX = 9;
    localparam int DEB     = 4;
    localparam int NW      = DIGITS * DIG_W;
    localparam logic [NW-1:0] INIT = 8'h12;
`ifdef NUMBER_ENTRY_DEC_EN
    localparam int NB = 2 * DIGITS;
`else
    localparam int NB = DIGITS;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          load;
    logic [NW-1:0] load_val;
    logic [NB-1:0] raw;
    logic [DIGITS-1:0] btn_inc;
    logic [NW-1:0] num_c0, num_c1;
    logic          chg_c0, chg_c1, ovf_c0, ovf_c1;

    assign btn_inc = raw[DIGITS-1:0];
`ifdef NUMBER_ENTRY_DEC_EN
    logic [DIGITS-1:0] btn_dec;
    assign btn_dec = raw[NB-1:DIGITS];
`endif

    always #5 clk = ~clk;

    number_entry #(.DIGITS(DIGITS), .DIG_W(DIG_W), .DIG_MAX(DIG_MAX), .INIT(INIT),
                   .DEB_TICKS(DEB), .CARRY(0)) u_dut_c0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_inc(btn_inc),
`ifdef NUMBER_ENTRY_DEC_EN
        .btn_dec(btn_dec),
`endif
        .load(load), .load_val(load_val), .num(num_c0), .changed(chg_c0), .ovf(ovf_c0));

    number_entry #(.DIGITS(DIGITS), .DIG_W(DIG_W), .DIG_MAX(DIG_MAX), .INIT(INIT),
                   .DEB_TICKS(DEB), .CARRY(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_inc(btn_inc),
`ifdef NUMBER_ENTRY_DEC_EN
        .btn_dec(btn_dec),
`endif
        .load(load), .load_val(load_val), .num(num_c1), .changed(chg_c1), .ovf(ovf_c1));

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int n_chg[2];
    int n_ovf[2];

    // ---------------- behavioural model ----------------
    bit [NB-1:0]     d0, d1, m_stable, pipe0, pipe1;
    bit              win [NB][DEB];
    int              nwin [NB];
    bit [DIGITS-1:0] m_pinc, m_pdec;
    int              m_dig [2][DIGITS];
    logic [NW-1:0]   exp_num [2];
    bit              exp_chg [2];
    bit              exp_ovf [2];

    task automatic pack_model();
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < DIGITS; j++)
                exp_num[c][j*DIG_W +: DIG_W] = DIG_W'(m_dig[c][j]);
    endtask

    // State the model holds after the coming clock edge, given current inputs.
    task automatic model_edge();
        bit [NB-1:0]     pin_now;
        bit [DIGITS-1:0] pi, pd;
        bit              smp, ok, up, wrap;
        int              tgt, j;
        if (!rst_n) begin
            d0 = '0; d1 = '0; m_stable = '0; pipe0 = '0; pipe1 = '0;
            for (int b = 0; b < NB; b++) nwin[b] = 0;
            m_pinc = '0; m_pdec = '0;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < DIGITS; k++) m_dig[c][k] = int'(INIT[k*DIG_W +: DIG_W]);
                exp_chg[c] = 1'b0;
                exp_ovf[c] = 1'b0;
            end
            pack_model();
            return;
        end
        // accepted presses reach the pending flags two edges after acceptance
        pin_now = pipe1;
        pipe1   = pipe0;
        for (int b = 0; b < NB; b++) begin
            smp      = d1[b];
            d1[b]    = d0[b];
            d0[b]    = raw[b];
            pipe0[b] = 1'b0;
            if (tick) begin
                for (int k = 0; k < DEB - 1; k++) win[b][k] = win[b][k+1];
                win[b][DEB-1] = smp;
                if (nwin[b] < DEB) nwin[b]++;
                ok = (nwin[b] == DEB);
                for (int k = 0; k < DEB; k++) if (win[b][k] == m_stable[b]) ok = 1'b0;
                if (ok) begin
                    m_stable[b] = smp;
                    nwin[b]     = 0;
                    pipe0[b]    = smp;
                end
            end
        end
        pi = pin_now[DIGITS-1:0];
        pd = '0;
`ifdef NUMBER_ENTRY_DEC_EN
        pd = pin_now[NB-1:DIGITS];
`endif
        if (load) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < DIGITS; k++) m_dig[c][k] = int'(load_val[k*DIG_W +: DIG_W]);
                exp_chg[c] = 1'b1;
                exp_ovf[c] = 1'b0;
            end
            m_pinc = '0;
            m_pdec = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                exp_chg[c] = 1'b0;
                exp_ovf[c] = 1'b0;
            end
            tgt = -1;
            for (int i = DIGITS - 1; i >= 0; i--) if (m_pinc[i] || m_pdec[i]) tgt = i;
            if (tgt >= 0) begin
                up = m_pinc[tgt];
                if (!(m_pinc[tgt] && m_pdec[tgt])) begin
                    for (int c = 0; c < 2; c++) begin
                        j = tgt;
                        do begin
                            if (up) begin
                                if (m_dig[c][j] >= DIG_MAX) begin m_dig[c][j] = 0; wrap = 1'b1; end
                                else begin m_dig[c][j] += 1; wrap = 1'b0; end
                            end else begin
                                if (m_dig[c][j] == 0) begin m_dig[c][j] = DIG_MAX; wrap = 1'b1; end
                                else begin m_dig[c][j] -= 1; wrap = 1'b0; end
                            end
                            j++;
                        end while (c == 1 && wrap && j < DIGITS);
                        exp_ovf[c] = (c == 1) && wrap && (j == DIGITS);
                        exp_chg[c] = 1'b1;
                    end
                end
                m_pinc[tgt] = 1'b0;
                m_pdec[tgt] = 1'b0;
            end
            m_pinc = m_pinc | pi;
            m_pdec = m_pdec | pd;
        end
        pack_model();
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic cmp_dut(input int c, input logic [NW-1:0] n, input logic ch, input logic ov);
        vectors++;
        if (n !== exp_num[c] || ch !== exp_chg[c] || ov !== exp_ovf[c]) begin
            miscompares++;
            $display("FAIL cycle_c%0d @%0t: num=%h changed=%b ovf=%b, required num=%h changed=%b ovf=%b",
                     c, $time, n, ch, ov, exp_num[c], exp_chg[c], exp_ovf[c]);
        end
        if (ch === 1'b1) n_chg[c]++;
        if (ov === 1'b1) n_ovf[c]++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                cmp_dut(0, num_c0, chg_c0, ovf_c0);
                cmp_dut(1, num_c1, chg_c1, ovf_c1);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        raw[b] = 1'b1;
        repeat (hold) cyc();
        raw[b] = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic do_load(input logic [NW-1:0] v);
        load = 1'b1;
        load_val = v;
        cyc();
        load = 1'b0;
        cyc();
    endtask

    int base0, base1, ob0, ob1;
    int dur [NB];

    initial begin
        rst_n = 1'b0; tick = 1'b1; load = 1'b0; load_val = '0; raw = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        check("reset_num_c0", 32'(num_c0), 32'h12);
        check("reset_num_c1", 32'(num_c1), 32'h12);
        check("reset_pulses", {30'd0, chg_c0 | chg_c1, ovf_c0 | ovf_c1}, 32'h0);
        check("model_reset", 32'(exp_num[1]), 32'h12);
        check("idle_no_change", 32'(n_chg[0] + n_chg[1]), 32'd0);

        press(0, 3);
        check("short_bounce", 32'(num_c0), 32'h12);

        base0 = n_chg[0];
        press(0, 10);
        check("held_inc_c0", 32'(num_c0), 32'h13);
        check("held_inc_c1", 32'(num_c1), 32'h13);
        check("held_one_pulse", 32'(n_chg[0] - base0), 32'd1);
        check("model_held", 32'(exp_num[0]), 32'h13);

        do_load(8'h19);
        press(0, 10);
        check("wrap_nocarry", 32'(num_c0), 32'h10);
        check("wrap_carry", 32'(num_c1), 32'h20);
        check("model_carry", 32'(exp_num[1]), 32'h20);

        do_load(8'h99);
        ob0 = n_ovf[0]; ob1 = n_ovf[1];
        press(0, 10);
        check("top_nocarry", 32'(num_c0), 32'h90);
        check("top_carry", 32'(num_c1), 32'h00);
        check("ovf_carry", 32'(n_ovf[1] - ob1), 32'd1);
        check("ovf_nocarry", 32'(n_ovf[0] - ob0), 32'd0);

        do_load(8'h12);
        base0 = n_chg[0]; base1 = n_chg[1];
        raw[0] = 1'b1; raw[1] = 1'b1;
        repeat (10) cyc();
        raw = '0;
        repeat (12) cyc();
        check("two_digits_c0", 32'(num_c0), 32'h23);
        check("two_digits_c1", 32'(num_c1), 32'h23);
        check("two_pulses", 32'(n_chg[1] - base1), 32'd2);

        raw[0] = 1'b1;
        repeat (8) cyc();
        load = 1'b1; load_val = 8'h55;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        raw[0] = 1'b0;
        repeat (12) cyc();
        check("load_beats_pending", 32'(num_c0), 32'h55);
        check("model_load", 32'(exp_num[0]), 32'h55);

`ifdef NUMBER_ENTRY_DEC_EN
        do_load(8'h10);
        press(DIGITS, 10);
        check("dec_nocarry", 32'(num_c0), 32'h19);
        check("dec_borrow", 32'(num_c1), 32'h09);
        base0 = n_chg[0];
        raw[0] = 1'b1; raw[DIGITS] = 1'b1;
        repeat (10) cyc();
        raw = '0;
        repeat (12) cyc();
        check("cancel_num", 32'(num_c0), 32'h19);
        check("cancel_pulse", 32'(n_chg[0] - base0), 32'd0);
`endif

        raw[0] = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        raw[0] = 1'b0;
        base0 = n_chg[0];
        repeat (14) cyc();
        check("reset_mid_debounce", 32'(num_c0), 32'h12);
        check("reset_mid_no_pulse", 32'(n_chg[0] - base0), 32'd0);

        for (int b = 0; b < NB; b++) dur[b] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < NB; b++) begin
                if (dur[b] == 0) begin
                    raw[b] = 1'($urandom_range(0, 1));
                    dur[b] = $urandom_range(1, 14);
                end else begin
                    dur[b]--;
                end
            end
            tick     = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 199) == 0);
            load_val = NW'($urandom);
            rst_n    = ($urandom_range(0, 999) != 0);
            cyc();
        end
        rst_n = 1'b1; load = 1'b0; tick = 1'b1; raw = '0;
        repeat (20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
